// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
// Pure declarations; no logic, no latency.
package clk_meas_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} meas_state_e;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes clk_in into the clk domain and flags its rising edges.
// q lags d by STAGES clk edges; rise is combinational from q and q delayed by one clk.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic w_s;
    logic r_s_d;

    generate
        if (STAGES == 0) begin : g_direct
            assign w_s = d;
        end else begin : g_sync
            logic [STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], d};
                end
            end

            assign w_s = r_sync[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign q    = w_s;
    assign rise = w_s & ~r_s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period, high time and low time of clk_in in clk cycles; flags lock and stall.
// Results are registered one clk after the synchronized rise is detected.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16'hFFFF,
    parameter int          LOCK_CNT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    // A timeout shorter than the smallest real period would fire on every cycle.
    localparam int unsigned      LP_TO_RAW  = (TIMEOUT < MIN_PERIOD) ? MIN_PERIOD : TIMEOUT;
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(LP_TO_RAW);
    localparam logic [3:0]       LP_LOCK    = 4'(LOCK_CNT);

    logic w_s;
    logic w_rise;

    meas_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_timeout;
    logic [3:0]       r_match_cnt;
    logic             r_first;
    logic [3:0]       w_match_next;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk_in),
        .q     (w_s),
        .rise  (w_rise)
    );

    // r_period still holds the previous result while r_cnt carries the new one.
    always_comb begin
        w_match_next = '0;
        if (!r_first && (r_cnt == r_period)) begin
            w_match_next = (r_match_cnt >= LP_LOCK) ? LP_LOCK : r_match_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_low        <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
            r_match_cnt  <= '0;
            r_first      <= 1'b1;
        end else begin
            r_meas_valid <= 1'b0;
            if (!en) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_hcnt      <= '0;
                r_match_cnt <= '0;
                r_locked    <= 1'b0;
                r_timeout   <= 1'b0;
                r_first     <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ALIGN;
                        r_first <= 1'b1;
                    end
                    ALIGN: begin
                        if (w_rise) begin
                            r_cnt     <= CNT_W'(1);
                            r_hcnt    <= CNT_W'(1);
                            r_timeout <= 1'b0;
                            r_state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // A rise on the timeout cycle is still a valid measurement.
                        if (w_rise) begin
                            r_period     <= r_cnt;
                            r_high       <= r_hcnt;
                            r_low        <= r_cnt - r_hcnt;
                            r_meas_valid <= 1'b1;
                            r_match_cnt  <= w_match_next;
                            r_locked     <= (w_match_next >= LP_LOCK);
                            r_first      <= 1'b0;
                            r_cnt        <= CNT_W'(1);
                            r_hcnt       <= CNT_W'(1);
                        end else if (r_cnt == LP_TIMEOUT) begin
                            r_timeout   <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_cnt <= '0;
                            r_first     <= 1'b1;
                            r_cnt       <= '0;
                            r_hcnt      <= '0;
                            r_state     <= ALIGN;
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_hcnt <= r_hcnt + CNT_W'(w_s);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign low_time   = r_low;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with a clk-synchronous programmable clk_in source.
module tb_clk_period_meter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clk_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [15:0] low_time;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    // clk_in source: gen_hi cycles high, gen_lo low; new settings apply at a period boundary
    bit gen_run = 0;
    int gen_hi  = 3;
    int gen_lo  = 3;
    int cur_hi  = 3;
    int cur_lo  = 3;
    int ph      = 0;

    clk_period_meter #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (100),
        .LOCK_CNT    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clk_in     (clk_in),
        .period     (period),
        .high_time  (high_time),
        .low_time   (low_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_run) begin
                clk_in = 1'b0;
                ph     = 0;
            end else begin
                if (ph == 0) begin
                    cur_hi = gen_hi;
                    cur_lo = gen_lo;
                end
                clk_in = (ph < cur_hi);
                ph     = (ph + 1 >= cur_hi + cur_lo) ? 0 : ph + 1;
            end
        end
    end

    task automatic wait_meas(input int budget, output bit ok, output int waited);
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            waited++;
            if (meas_valid) ok = 1'b1;
        end
    endtask

    task automatic restart(input int hi, input int lo);
        en      = 1'b0;
        gen_run = 1'b0;
        repeat (4) @(negedge clk);
        gen_hi  = hi;
        gen_lo  = lo;
        en      = 1'b1;
        gen_run = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        gen_run = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({period, high_time, low_time} !== 48'd0) begin
            n_err++;
            $display("FAIL reset_meas: got p=%0d h=%0d l=%0d, want 0/0/0", period, high_time, low_time);
        end
        n_cmp++;
        if ({meas_valid, locked, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got mv=%b lk=%b to=%b, want 000", meas_valid, locked, timeout);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs n measurements and checks each against fixed p/h and lock on measurement lock_at onward.
    task automatic run_and_check(input string name, input int n, input int p, input int h, input int lock_at);
        bit ok;
        int w;
        for (int i = 1; i <= n; i++) begin
            wait_meas(300, ok, w);
            n_cmp++;
            if (!ok || period !== 16'(p) || high_time !== 16'(h) || low_time !== 16'(p - h)
                    || locked !== (i >= lock_at) || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL %s[%0d]: got ok=%b p=%0d h=%0d l=%0d lk=%b to=%b, want p=%0d h=%0d l=%0d lk=%b to=0",
                         name, i, ok, period, high_time, low_time, locked, timeout,
                         p, h, p - h, (i >= lock_at));
            end
        end
    endtask

    task automatic test_lock_50();
        restart(3, 3);
        run_and_check("lock50", 3, 6, 3, 3);
    endtask

    task automatic test_asym_duty();
        restart(1, 4);
        run_and_check("asym", 3, 5, 1, 3);
    endtask

    task automatic test_ratio_change();
        int exp_p [4] = '{6, 4, 4, 4};
        int exp_h [4] = '{3, 2, 2, 2};
        bit exp_lk[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit ok;
        int w;
        restart(3, 3);
        run_and_check("ratio_pre", 3, 6, 3, 3);
        gen_hi = 2;
        gen_lo = 2;
        for (int i = 0; i < 4; i++) begin
            wait_meas(40, ok, w);
            n_cmp++;
            if (!ok || period !== 16'(exp_p[i]) || high_time !== 16'(exp_h[i])
                    || low_time !== 16'(exp_p[i] - exp_h[i]) || locked !== exp_lk[i]) begin
                n_err++;
                $display("FAIL ratio[%0d]: got ok=%b p=%0d h=%0d l=%0d lk=%b, want p=%0d h=%0d l=%0d lk=%b",
                         i, ok, period, high_time, low_time, locked,
                         exp_p[i], exp_h[i], exp_p[i] - exp_h[i], exp_lk[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit saw_mv;
        int w;
        int k;
        int first_k;
        wait_meas(40, ok, w);
        gen_run = 1'b0;
        n_cmp++;
        if (!ok || period !== 16'd4 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL to_pre: got ok=%b p=%0d lk=%b, want p=4 lk=1", ok, period, locked);
        end
        saw_mv  = 1'b0;
        first_k = 0;
        k       = 0;
        while (first_k == 0 && k < 130) begin
            @(negedge clk);
            k++;
            if (meas_valid) saw_mv = 1'b1;
            if (timeout) first_k = k;
        end
        n_cmp++;
        if (first_k != 100 || locked !== 1'b0 || saw_mv) begin
            n_err++;
            $display("FAIL to_fire: got cycle=%0d lk=%b mv_seen=%b, want cycle=100 lk=0 mv_seen=0",
                     first_k, locked, saw_mv);
        end
        gen_hi  = 4;
        gen_lo  = 4;
        gen_run = 1'b1;
        saw_mv  = 1'b0;
        k       = 0;
        while (timeout && k < 20) begin
            @(negedge clk);
            k++;
            if (meas_valid) saw_mv = 1'b1;
        end
        n_cmp++;
        if (timeout !== 1'b0 || saw_mv) begin
            n_err++;
            $display("FAIL to_clear: got to=%b mv_seen=%b, want to=0 mv_seen=0", timeout, saw_mv);
        end
        wait_meas(40, ok, w);
        n_cmp++;
        if (!ok || period !== 16'd8 || high_time !== 16'd4 || low_time !== 16'd4
                || timeout !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL to_resume: got ok=%b p=%0d h=%0d l=%0d to=%b lk=%b, want p=8 h=4 l=4 to=0 lk=0",
                     ok, period, high_time, low_time, timeout, locked);
        end
    endtask

    task automatic test_timeout_edge();
        restart(50, 50);
        run_and_check("to_edge", 2, 100, 50, 99);
    endtask

    task automatic test_min_period();
        restart(1, 1);
        run_and_check("minp", 3, 2, 1, 3);
    endtask

    task automatic test_enable_mid();
        bit ok;
        bit saw_mv;
        int w;
        restart(3, 3);
        run_and_check("en_pre", 3, 6, 3, 3);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (locked !== 1'b0 || timeout !== 1'b0 || period !== 16'd6 || high_time !== 16'd3 || low_time !== 16'd3) begin
            n_err++;
            $display("FAIL en_drop: got lk=%b to=%b p=%0d h=%0d l=%0d, want lk=0 to=0 p=6 h=3 l=3",
                     locked, timeout, period, high_time, low_time);
        end
        saw_mv = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (meas_valid) saw_mv = 1'b1;
        end
        n_cmp++;
        if (saw_mv) begin
            n_err++;
            $display("FAIL en_idle: got meas_valid while disabled, want none");
        end
        en = 1'b1;
        wait_meas(40, ok, w);
        n_cmp++;
        if (!ok || w < 8 || period !== 16'd6 || high_time !== 16'd3 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL en_resume: got ok=%b wait=%0d p=%0d h=%0d lk=%b, want wait>=8 p=6 h=3 lk=0",
                     ok, w, period, high_time, locked);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int w;
        restart(3, 3);
        wait_meas(40, ok, w);
        wait_meas(40, ok, w);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({period, high_time, low_time} !== 48'd0 || {meas_valid, locked, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid: got p=%0d h=%0d l=%0d mv=%b lk=%b to=%b, want all 0",
                     period, high_time, low_time, meas_valid, locked, timeout);
        end
        @(negedge clk);
        n_cmp++;
        if ({period, meas_valid, locked} !== 18'd0) begin
            n_err++;
            $display("FAIL rst_hold: got p=%0d mv=%b lk=%b, want 0/0/0", period, meas_valid, locked);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_lock_50();
        test_asym_duty();
        test_ratio_change();
        test_timeout();
        test_timeout_edge();
        test_min_period();
        test_enable_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
